// File: rtl/trng_ctrl_pkg.sv
// rtl/trng_ctrl_pkg.sv - shared constants and state encoding for the TRNG controller
package trng_ctrl_pkg;

   localparam int BYTE_W            = 8;
   localparam int DEF_WARMUP_CYCLES = 16;
   localparam int DEF_REP_LIMIT     = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ENABLE  = 3'd1,
      ST_WARMUP  = 3'd2,
      ST_COLLECT = 3'd3,
      ST_HOLD    = 3'd4,
      ST_FAULT   = 3'd5
   } state_t;

endpackage

// File: rtl/trng_health_rep.sv
// rtl/trng_health_rep.sv - repetition-count health test on the de-biased bit stream
module trng_health_rep
   import trng_ctrl_pkg::*;
#(
   parameter int REP_LIMIT = DEF_REP_LIMIT
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_bit,
   input  logic i_valid,
   output logic o_fail
);

   logic [3:0] rep_cnt;
   logic [3:0] rep_nxt;
   logic       last_bit;

   // A zero count means no previous bit since the last clear.
   always_comb begin
      rep_nxt = rep_cnt;
      if (i_valid) begin
         if (rep_cnt == 4'd0 || i_bit != last_bit)
            rep_nxt = 4'd1;
         else if (rep_cnt != 4'hF)
            rep_nxt = rep_cnt + 4'd1;
      end
   end

   assign o_fail = i_valid && !i_clear && (rep_nxt >= 4'(REP_LIMIT));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rep_cnt  <= 4'd0;
         last_bit <= 1'b0;
      end else if (i_clear) begin
         rep_cnt  <= 4'd0;
      end else if (i_valid) begin
         rep_cnt  <= rep_nxt;
         last_bit <= i_bit;
      end
   end

endmodule

// File: rtl/trng_ctrl.sv
// rtl/trng_ctrl.sv - TRNG controller: enable/warm-up sequencing, byte assembly and health fault
module trng_ctrl
   import trng_ctrl_pkg::*;
#(
   parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
   parameter int REP_LIMIT     = DEF_REP_LIMIT
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_stop,
   input  logic              i_chainReady,
   input  logic              i_random,
   input  logic              i_valid,
   input  logic              i_dataReady,
   output logic              o_enSim,
   output logic [BYTE_W-1:0] o_data,
   output logic              o_dataValid,
   output logic              o_busy,
   output logic              o_fault
);

   state_t            state, state_nxt;
   logic [7:0]        warm_cnt;
   logic [2:0]        bit_cnt;
   logic [BYTE_W-2:0] shift_q;
   logic [BYTE_W-1:0] pend_q;
   logic [BYTE_W-1:0] data_q;
   logic              valid_q;
   logic              en_q, busy_q, fault_q;
   logic              en_nxt, busy_nxt, fault_nxt;

   logic              bit_in;
   logic              byte_done;
   logic              consume;
   logic              can_load;
   logic              health_fail;
   logic              health_clear;
   logic [BYTE_W-1:0] new_byte;

   assign bit_in       = (state == ST_COLLECT) && i_valid;
   assign byte_done    = bit_in && (bit_cnt == 3'd7);
   assign consume      = valid_q && i_dataReady;
   assign can_load     = !valid_q || i_dataReady;
   assign new_byte     = {shift_q, i_random};
   assign health_clear = (state != ST_COLLECT) && (state != ST_HOLD);

   trng_health_rep #(.REP_LIMIT(REP_LIMIT)) u_health (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clear (health_clear),
      .i_bit   (i_random),
      .i_valid (bit_in),
      .o_fail  (health_fail)
   );

   // Status outputs are registered from the next state so they cannot glitch.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= ST_IDLE;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         en_q    <= en_nxt;
         busy_q  <= busy_nxt;
         fault_q <= fault_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (i_start && !i_stop) state_nxt = ST_ENABLE;
         ST_ENABLE:  if (i_stop) state_nxt = ST_IDLE;
                     else if (i_chainReady) state_nxt = ST_WARMUP;
         ST_WARMUP:  if (i_stop) state_nxt = ST_IDLE;
                     else if (warm_cnt == 8'd0) state_nxt = ST_COLLECT;
         ST_COLLECT: if (i_stop) state_nxt = ST_IDLE;
                     else if (health_fail) state_nxt = ST_FAULT;
                     else if (byte_done && !can_load) state_nxt = ST_HOLD;
         ST_HOLD:    if (i_stop) state_nxt = ST_IDLE;
                     else if (consume) state_nxt = ST_COLLECT;
         ST_FAULT:   if (i_stop) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      en_nxt    = 1'b0;
      busy_nxt  = (state_nxt != ST_IDLE);
      fault_nxt = (state_nxt == ST_FAULT);
      case (state_nxt)
         ST_ENABLE, ST_WARMUP, ST_COLLECT, ST_HOLD: en_nxt = 1'b1;
         default:                                   en_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         warm_cnt <= 8'd0;
         bit_cnt  <= 3'd0;
         shift_q  <= '0;
         pend_q   <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         if (consume)
            valid_q <= 1'b0;
         case (state)
            ST_ENABLE: begin
               if (!i_stop && i_chainReady)
                  warm_cnt <= 8'(WARMUP_CYCLES - 1);
            end
            ST_WARMUP: begin
               if (warm_cnt != 8'd0)
                  warm_cnt <= warm_cnt - 8'd1;
               bit_cnt <= 3'd0;
               shift_q <= '0;
            end
            ST_COLLECT: begin
               if (i_stop) begin
                  bit_cnt <= 3'd0;
                  shift_q <= '0;
                  pend_q  <= '0;
               end else if (health_fail) begin
                  valid_q <= 1'b0;
                  bit_cnt <= 3'd0;
                  shift_q <= '0;
                  pend_q  <= '0;
               end else if (bit_in) begin
                  shift_q <= new_byte[BYTE_W-2:0];
                  bit_cnt <= bit_cnt + 3'd1;
                  if (byte_done) begin
                     if (can_load) begin
                        data_q  <= new_byte;
                        valid_q <= 1'b1;
                     end else begin
                        pend_q  <= new_byte;
                     end
                  end
               end
            end
            ST_HOLD: begin
               if (i_stop) begin
                  bit_cnt <= 3'd0;
                  shift_q <= '0;
                  pend_q  <= '0;
               end else if (consume) begin
                  data_q  <= pend_q;
                  valid_q <= 1'b1;
                  pend_q  <= '0;
               end
            end
            ST_FAULT: begin
               valid_q <= 1'b0;
               bit_cnt <= 3'd0;
               shift_q <= '0;
               pend_q  <= '0;
            end
            default: ;
         endcase
      end
   end

   assign o_enSim     = en_q;
   assign o_busy      = busy_q;
   assign o_fault     = fault_q;
   assign o_data      = data_q;
   assign o_dataValid = valid_q;

endmodule

// File: tb/tb_trng_ctrl.sv
// tb/tb_trng_ctrl.sv - self-checking bench for trng_ctrl
module tb_trng_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, stop = 1'b0, chain = 1'b0;
   logic       rnd = 1'b0, vld = 1'b0, rdy = 1'b0;
   logic       en_sim, dv, busy, fault;
   logic [7:0] data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   trng_ctrl dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start),
      .i_stop       (stop),
      .i_chainReady (chain),
      .i_random     (rnd),
      .i_valid      (vld),
      .i_dataReady  (rdy),
      .o_enSim      (en_sim),
      .o_data       (data),
      .o_dataValid  (dv),
      .o_busy       (busy),
      .o_fault      (fault)
   );

   typedef struct {
      logic start, stop, chain;
      logic en, busy;
   } vec_t;

   vec_t tbl [9];

   // reference model state for the randomized run
   logic       m_full, m_pend_full, m_last;
   logic [7:0] m_byte, m_pend, m_acc;
   int         m_n, m_run;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic feed_bits(input logic [7:0] b, input int nbits, input logic r);
      for (int i = 7; i > 7 - nbits; i--) begin
         vld = 1'b1; rnd = b[i]; rdy = r;
         step();
      end
      vld = 1'b0;
   endtask

   task automatic reach_collect();
      start = 1'b1; stop = 1'b0; chain = 1'b0;
      step();
      start = 1'b0; chain = 1'b1;
      step();
      chain = 1'b0; vld = 1'b1; rnd = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         chk($sformatf("warmup_en%0d", i), en_sim, 1);
         chk($sformatf("warmup_fault%0d", i), fault, 0);
      end
      vld = 1'b0;
   endtask

   initial begin
      tbl[0] = '{1, 1, 0, 0, 0};
      tbl[1] = '{1, 0, 0, 1, 1};
      tbl[2] = '{0, 0, 0, 1, 1};
      tbl[3] = '{0, 0, 1, 1, 1};
      tbl[4] = '{0, 0, 0, 1, 1};
      tbl[5] = '{0, 1, 0, 0, 0};
      tbl[6] = '{0, 0, 0, 0, 0};
      tbl[7] = '{1, 0, 1, 1, 1};
      tbl[8] = '{0, 1, 0, 0, 0};

      // reset state, observed while reset is still held
      #2;
      chk("rst_en", en_sim, 0); chk("rst_busy", busy, 0); chk("rst_dv", dv, 0);
      chk("rst_fault", fault, 0); chk("rst_data", data, 0);
      step(); step();
      rst = 1'b0;
      step();

      // IDLE/ENABLE/WARMUP transitions, stop and start+stop handling
      for (int i = 0; i < 9; i++) begin
         start = tbl[i].start; stop = tbl[i].stop; chain = tbl[i].chain;
         vld = 1'b1; rnd = 1'b1;
         step();
         chk($sformatf("tbl%0d_en", i), en_sim, tbl[i].en);
         chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
         chk($sformatf("tbl%0d_dv", i), dv, 0);
      end
      start = 1'b0; stop = 1'b0; chain = 1'b0; vld = 1'b0;

      // start, chain ready two cycles later, 16 warm-up cycles, then 0xB2
      start = 1'b1; step();
      chk("b2_en_enable", en_sim, 1);
      start = 1'b0; step();
      chain = 1'b1; step();
      chain = 1'b0;
      vld = 1'b1; rnd = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         chk($sformatf("b2_warm_dv%0d", i), dv, 0);
      end
      feed_bits(8'hB2, 7, 1'b1);
      chk("b2_dv_7bits", dv, 0);
      vld = 1'b1; rnd = 1'b0; step(); vld = 1'b0;
      chk("b2_dv", dv, 1); chk("b2_data", data, 8'hB2);

      // second byte completes while first is unconsumed -> HOLD
      rdy = 1'b0; step();
      feed_bits(8'h5A, 8, 1'b0);
      chk("hold_dv", dv, 1); chk("hold_data", data, 8'hB2); chk("hold_busy", busy, 1);
      feed_bits(8'hA8, 5, 1'b0);
      chk("hold_data_kept", data, 8'hB2);
      rdy = 1'b1; step();
      chk("hold_release_dv", dv, 1); chk("hold_release_data", data, 8'h5A);
      step();
      chk("hold_drain_dv", dv, 0);

      // byte completes on the same cycle as the previous handshake
      feed_bits(8'h96, 8, 1'b0);
      chk("b2b_first", data, 8'h96);
      feed_bits(8'h3C, 7, 1'b0);
      chk("b2b_wait", data, 8'h96);
      vld = 1'b1; rnd = 1'b0; rdy = 1'b1; step(); vld = 1'b0;
      chk("b2b_dv", dv, 1); chk("b2b_data", data, 8'h3C);
      step();
      chk("b2b_drain", dv, 0);

      // stop mid-byte keeps the visible byte and drops the partial one
      feed_bits(8'hA5, 8, 1'b0);
      feed_bits(8'hE0, 3, 1'b0);
      stop = 1'b1; step(); stop = 1'b0;
      chk("stop_busy", busy, 0); chk("stop_en", en_sim, 0);
      chk("stop_dv", dv, 1); chk("stop_data", data, 8'hA5);
      rdy = 1'b1; step();
      chk("stop_drain", dv, 0);
      reach_collect();
      feed_bits(8'hC3, 8, 1'b1);
      chk("restart_dv", dv, 1); chk("restart_data", data, 8'hC3);
      step();

      // eight consecutive ones -> FAULT
      feed_bits(8'h52, 8, 1'b0);
      chk("pre_fault_dv", dv, 1);
      feed_bits(8'hFF, 7, 1'b0);
      chk("pre_fault", fault, 0);
      vld = 1'b1; rnd = 1'b1; step(); vld = 1'b0;
      chk("fault_set", fault, 1); chk("fault_en", en_sim, 0);
      chk("fault_dv", dv, 0); chk("fault_busy", busy, 1);
      start = 1'b1; step(); step(); start = 1'b0;
      chk("fault_sticky", fault, 1);
      stop = 1'b1; step(); stop = 1'b0;
      chk("fault_clear", fault, 0); chk("fault_idle", busy, 0);

      // stop wins over a fault detected in the same cycle
      reach_collect();
      feed_bits(8'hFF, 7, 1'b1);
      vld = 1'b1; rnd = 1'b1; stop = 1'b1; step(); vld = 1'b0; stop = 1'b0;
      chk("prio_fault", fault, 0); chk("prio_busy", busy, 0); chk("prio_dv", dv, 0);

      // asynchronous reset mid-COLLECT with a byte showing
      reach_collect();
      feed_bits(8'h69, 8, 1'b0);
      chk("arst_pre_dv", dv, 1);
      rst = 1'b1; #1;
      chk("arst_en", en_sim, 0); chk("arst_busy", busy, 0); chk("arst_dv", dv, 0);
      chk("arst_fault", fault, 0); chk("arst_data", data, 0);
      step();
      rst = 1'b0;
      step();
      chk("arst_idle", busy, 0);

      // randomized traffic against a byte-occupancy model
      reach_collect();
      m_full = 0; m_pend_full = 0; m_last = 0; m_byte = 0; m_pend = 0; m_acc = 0;
      m_n = 0; m_run = 0;
      for (int c = 0; c < 1500; c++) begin
         logic v, r, b, consume;
         v = ($urandom % 4) != 0;
         r = ($urandom % 3) != 0;
         b = 1'($urandom % 2);
         if (v && !m_pend_full && m_run == 7 && b == m_last) b = ~m_last;
         vld = v; rdy = r; rnd = b;
         step();
         consume = m_full && r;
         if (m_pend_full) begin
            if (consume) begin
               m_byte = m_pend;
               m_pend_full = 0;
            end
         end else begin
            if (consume) m_full = 0;
            if (v) begin
               m_run = (m_run == 0 || b != m_last) ? 1 : m_run + 1;
               m_last = b;
               m_acc = {m_acc[6:0], b};
               m_n++;
               if (m_n == 8) begin
                  m_n = 0;
                  if (!m_full) begin
                     m_full = 1; m_byte = m_acc;
                  end else begin
                     m_pend = m_acc; m_pend_full = 1;
                  end
               end
            end
         end
         chk($sformatf("rnd%0d_dv", c), dv, m_full);
         if (m_full) chk($sformatf("rnd%0d_data", c), data, m_byte);
         chk($sformatf("rnd%0d_fault", c), fault, 0);
      end
      vld = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
